// File: rtl/instr_mem_block_pkg.sv
// Shared definitions for the block-fetch instruction memory: FSM state encoding,
// default geometry and the bytes-per-word helper.
package instr_mem_block_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_WORD_WIDTH  = 32;
    localparam int DEFAULT_BLOCK_WORDS = 4;
    localparam int DEFAULT_LATENCY     = 40;
    localparam int BYTES_PER_WORD      = DEFAULT_WORD_WIDTH / 8;

    function automatic int bytes_per_word(input int word_width);
        return word_width / 8;
    endfunction

endpackage

// File: rtl/instr_mem_block_latency_counter.sv
// Down-counter that times one memory request; zero is high once the count has
// expired and stays there until the next load.
module imem_latency_counter
    import instr_mem_block_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // NOTE: state is written with <= so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/instr_mem_block.sv
// Block-fetch instruction memory with fixed multi-cycle latency and busywait.
// Optional IMEM_RANGE_CHECK_EN adds an error output for blocks past the end.
module instr_mem_block
    import instr_mem_block_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_WIDTH  = 6,
    parameter int LATENCY     = DEFAULT_LATENCY,
    parameter logic [DEPTH_BYTES*8-1:0] INIT_IMAGE = '0
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              read,
    input  logic [ADDR_WIDTH-1:0]             address,
    output logic [WORD_WIDTH*BLOCK_WORDS-1:0] readdata,
`ifdef IMEM_RANGE_CHECK_EN
    output logic                              error,
`endif
    output logic                              busywait
);

    localparam int BPW         = bytes_per_word(WORD_WIDTH);
    localparam int BLOCK_BYTES = BPW * BLOCK_WORDS;
    localparam int RD_W        = WORD_WIDTH * BLOCK_WORDS;
    localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IMG_IDX_W   = $clog2(DEPTH_BYTES * 8);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [RD_W-1:0]       r_readdata;
    logic                  r_busywait;
    logic [31:0]           w_base;
    logic [RD_W-1:0]       w_block;
    logic                  w_load;
    logic                  w_tick;
    logic                  w_zero;
`ifdef IMEM_RANGE_CHECK_EN
    logic                  r_error;
    logic                  w_oob;
`endif

    assign w_load = (r_state == IDLE) && read;
    assign w_tick = (r_state == BUSY);
    assign w_base = 32'(r_addr_q) * 32'(BLOCK_BYTES);

    imem_latency_counter #(
        .WIDTH(CNT_W)
    ) u_counter (
        .CLK     (CLK),
        .RESET   (RESET),
        .load    (w_load),
        .load_val(CNT_W'(LATENCY - 1)),
        .tick    (w_tick),
        .zero    (w_zero)
    );

    // Little-endian gather: lowest byte address lands in the block LSB.
    always_comb begin
        logic [31:0]          byte_idx;
        logic [IMG_IDX_W-1:0] bit_base;
        // NOTE: every comb output gets a default first, so no path infers a latch.
        w_block  = '0;
        byte_idx = '0;
        bit_base = '0;
        for (int j = 0; j < BLOCK_BYTES; j++) begin
            byte_idx           = (w_base + 32'(j)) % 32'(DEPTH_BYTES);
            bit_base           = IMG_IDX_W'(byte_idx * 32'd8);
            w_block[j*8 +: 8]  = INIT_IMAGE[bit_base +: 8];
        end
    end

`ifdef IMEM_RANGE_CHECK_EN
    assign w_oob = (w_base + 32'(BLOCK_BYTES)) > 32'(DEPTH_BYTES);
`endif

    // NOTE: reset clears only control and output registers; the image is a ROM and is never reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_addr_q   <= '0;
            r_readdata <= '0;
            r_busywait <= 1'b0;
`ifdef IMEM_RANGE_CHECK_EN
            r_error    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (read) begin
                        r_addr_q   <= address;
                        r_busywait <= 1'b1;
                        r_state    <= BUSY;
`ifdef IMEM_RANGE_CHECK_EN
                        r_error    <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    if (w_zero) begin
`ifdef IMEM_RANGE_CHECK_EN
                        r_readdata <= w_oob ? '0 : w_block;
                        r_error    <= w_oob;
`else
                        r_readdata <= w_block;
`endif
                        r_busywait <= 1'b0;
                        r_state    <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign readdata = r_readdata;
    assign busywait = r_busywait;
`ifdef IMEM_RANGE_CHECK_EN
    assign error    = r_error;
`endif

endmodule

// File: tb/tb_instr_mem_block.sv
// Directed scoreboard bench for instr_mem_block: a default 40-cycle instance and a
// LATENCY=1, two-word, 32-byte instance; honours IMEM_RANGE_CHECK_EN.
module tb_instr_mem_block;

    function automatic logic [7:0] img_byte(input int i);
        logic [127:0] head;
        head = 128'h0B000400_00030001_00050003_00040005;
        if (i < 16) return head[i*8 +: 8];
        return 8'((i * 37 + 11) % 256);
    endfunction

    function automatic logic [8191:0] make_image();
        logic [8191:0] m;
        m = '0;
        for (int i = 0; i < 1024; i++) m[i*8 +: 8] = img_byte(i);
        return m;
    endfunction

    function automatic logic [127:0] exp_block(input int base, input int nbytes, input int depth);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < nbytes; j++) r[j*8 +: 8] = img_byte((base + j) % depth);
        return r;
    endfunction

    localparam logic [8191:0] IMG  = make_image();
    localparam logic [255:0]  IMG2 = IMG[255:0];

    logic         clk = 1'b0;
    logic         rst;
    logic         rd, rd2;
    logic [5:0]   addr, addr2;
    logic [127:0] rdata;
    logic [63:0]  rdata2;
    logic         busy, busy2;
`ifdef IMEM_RANGE_CHECK_EN
    logic         err, err2;
`endif

    int           n_vec = 0;
    int           n_bad = 0;
    logic [127:0] sb_q[$];

    always #5 clk = ~clk;

    instr_mem_block #(
        .INIT_IMAGE(IMG)
    ) u_dut (
        .CLK     (clk),
        .RESET   (rst),
        .read    (rd),
        .address (addr),
        .readdata(rdata),
`ifdef IMEM_RANGE_CHECK_EN
        .error   (err),
`endif
        .busywait(busy)
    );

    instr_mem_block #(
        .BLOCK_WORDS(2),
        .DEPTH_BYTES(32),
        .LATENCY    (1),
        .INIT_IMAGE (IMG2)
    ) u_dut2 (
        .CLK     (clk),
        .RESET   (rst),
        .read    (rd2),
        .address (addr2),
        .readdata(rdata2),
`ifdef IMEM_RANGE_CHECK_EN
        .error   (err2),
`endif
        .busywait(busy2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busywait-high samples from the accepting edge up to the falling edge.
    task automatic wait_done1(output int cycles);
        cycles = 1;
        forever begin
            tick();
            if (!busy || cycles >= 200) break;
            cycles++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int quiet;

        rst = 1'b1; rd = 1'b1; addr = '0; rd2 = 1'b0; addr2 = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_busy", 128'(busy), 128'd0);
            check("rst_data", rdata, 128'd0);
        end
        rst = 1'b0;

        tick();
        check("accept_after_rst", 128'(busy), 128'd1);
        sb_q.push_back(128'h0B000400_00030001_00050003_00040005);
        wait_done1(cyc);
        check("lat_basic", 128'(cyc), 128'd40);
        check("data_basic", rdata, sb_q.pop_front());
`ifdef IMEM_RANGE_CHECK_EN
        check("err_basic", 128'(err), 128'd0);
`endif
        rd = 1'b0;
        tick();
        check("resp_idle", 128'(busy), 128'd0);

        rd = 1'b1; addr = 6'd1;
        tick();
        check("accept_a1", 128'(busy), 128'd1);
        sb_q.push_back(exp_block(16, 16, 1024));
        addr = 6'd0; rd = 1'b0;
        wait_done1(cyc);
        check("lat_a1", 128'(cyc), 128'd40);
        check("data_captured_addr", rdata, sb_q.pop_front());
        tick();

        rd = 1'b1; addr = 6'd2;
        tick();
        check("accept_b2b_1", 128'(busy), 128'd1);
        sb_q.push_back(exp_block(32, 16, 1024));
        wait_done1(cyc);
        check("lat_b2b_1", 128'(cyc), 128'd40);
        check("data_b2b_1", rdata, sb_q.pop_front());
        addr = 6'd3;
        tick();
        check("b2b_resp_no_accept", 128'(busy), 128'd0);
        tick();
        check("b2b_accept_2", 128'(busy), 128'd1);
        sb_q.push_back(exp_block(48, 16, 1024));
        wait_done1(cyc);
        check("lat_b2b_2", 128'(cyc), 128'd40);
        check("data_b2b_2", rdata, sb_q.pop_front());
        rd = 1'b0;
        tick();
        check("hold_in_resp", rdata, exp_block(48, 16, 1024));

        rd = 1'b1; addr = 6'd5;
        tick();
        check("accept_pre_rst", 128'(busy), 128'd1);
        rd = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_data", rdata, 128'd0);
        rst = 1'b0;
        quiet = 0;
        repeat (45) begin
            tick();
            if (busy) quiet++;
        end
        check("no_completion_after_rst", 128'(quiet), 128'd0);

        rd = 1'b1; addr = 6'd6;
        tick();
        check("accept_post_rst", 128'(busy), 128'd1);
        sb_q.push_back(exp_block(96, 16, 1024));
        rd = 1'b0;
        wait_done1(cyc);
        check("lat_post_rst", 128'(cyc), 128'd40);
        check("data_post_rst", rdata, sb_q.pop_front());
        tick();

        rd2 = 1'b1; addr2 = 6'd3;
        tick();
        check("d2_accept_a3", 128'(busy2), 128'd1);
        sb_q.push_back(exp_block(24, 8, 32));
        tick();
        check("d2_lat1_a3", 128'(busy2), 128'd0);
        check("d2_data_a3", 128'(rdata2), sb_q.pop_front());
`ifdef IMEM_RANGE_CHECK_EN
        check("d2_err_a3", 128'(err2), 128'd0);
`endif
        rd2 = 1'b0;
        tick();

        rd2 = 1'b1; addr2 = 6'd4;
        tick();
        check("d2_accept_a4", 128'(busy2), 128'd1);
`ifdef IMEM_RANGE_CHECK_EN
        sb_q.push_back(128'd0);
`else
        sb_q.push_back(exp_block(32, 8, 32));
`endif
        tick();
        check("d2_lat1_a4", 128'(busy2), 128'd0);
        check("d2_data_a4", 128'(rdata2), sb_q.pop_front());
`ifdef IMEM_RANGE_CHECK_EN
        check("d2_err_a4", 128'(err2), 128'd1);
`endif
        rd2 = 1'b0;
        tick();
`ifdef IMEM_RANGE_CHECK_EN
        check("d2_err_held", 128'(err2), 128'd1);
`endif
        check("d2_data_held", 128'(rdata2), 128'(rdata2 === 64'd0 ? 64'd0 : exp_block(32, 8, 32)));

        check("sb_empty", 128'(sb_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
